// File: rtl/dds_pkg.sv
// dds_pkg: shared types and constants for the multi-channel DDS
// mode encoding, config addresses, control bit positions
package dds_pkg;

  typedef enum logic [1:0] {
    SINE   = 2'd0,
    SQUARE = 2'd1,
    SAW    = 2'd2,
    TRI    = 2'd3
  } mode_e;

  localparam logic [1:0] CFG_FREQ  = 2'd0;
  localparam logic [1:0] CFG_PHASE = 2'd1;
  localparam logic [1:0] CFG_MODE  = 2'd2;
  localparam logic [1:0] CFG_CTRL  = 2'd3;

  localparam int CTRL_CLR  = 0;
  localparam int CTRL_SYNC = 1;

endpackage

// File: rtl/dds_mc_if.sv
// dds_mc_if: config bus in, channel-tagged sample stream out
// master drives config/enable, slave is the synthesiser
interface dds_mc_if #(
  parameter int PW  = 32,
  parameter int DW  = 10,
  parameter int NCH = 4
);
  localparam int CW = $clog2(NCH);

  logic                 en;
  logic                 cfg_we;
  logic [CW-1:0]        cfg_ch;
  logic [1:0]           cfg_addr;
  logic [PW-1:0]        cfg_wdata;
  logic signed [DW-1:0] out;
  logic [CW-1:0]        out_ch;
  logic                 out_valid;
  logic                 out_frame;

  modport master (
    output en, cfg_we, cfg_ch,
    output cfg_addr, cfg_wdata,
    input  out, out_ch,
    input  out_valid, out_frame
  );

  modport slave (
    input  en, cfg_we, cfg_ch,
    input  cfg_addr, cfg_wdata,
    output out, out_ch,
    output out_valid, out_frame
  );

endinterface

// File: rtl/dds_quarter_lut.sv
// dds_quarter_lut: first-quadrant sine magnitudes
// sampled at bin centres, one-cycle registered read
module dds_quarter_lut #(
  parameter int DW = 10,
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-3:0] idx,
  output logic [DW-2:0] q
);
  localparam int  Q   = 2 ** (AW - 2);
  localparam real AMP = real'(2 ** (DW - 1) - 1);
  localparam real PI  = 3.14159265358979323846;

  function automatic logic [DW-2:0] qval(int k);
    real x;
    x = AMP * $sin(PI / 2.0 * (real'(k) + 0.5) / real'(Q));
    return (DW-1)'($rtoi(x + 0.5));
  endfunction

  logic [DW-2:0] rom [Q];

  for (genvar k = 0; k < Q; k++) begin : g_rom
    assign rom[k] = qval(k);
  end

  // registered read, frozen with the pipeline
  always_ff @(posedge clk) begin
    if (en) q <= rom[idx];
  end

endmodule

// File: rtl/dds_mc.sv
// dds_mc: time-multiplexed multi-channel DDS
// per-slot phase accumulate, shared quarter ROM, mode mux
module dds_mc
  import dds_pkg::*;
#(
  parameter int PW  = 32,
  parameter int DW  = 10,
  parameter int AW  = 13,
  parameter int NCH = 4
) (
  input logic     clk,
  input logic     rst,
  dds_mc_if.slave bus
);
  localparam int CW = $clog2(NCH);
  localparam int HW = (AW > DW + 1) ? AW : DW + 1;
  localparam logic [DW-1:0] AMP = {1'b0, {(DW-1){1'b1}}};

  typedef struct packed {
    logic          v;
    logic [CW-1:0] ch;
    mode_e         mode;
    logic [HW-1:0] ph;
  } stg_t;

  logic [PW-1:0] acc   [NCH];
  logic [PW-1:0] freq  [NCH];
  logic [PW-1:0] phase [NCH];
  mode_e         mode  [NCH];
  logic [CW-1:0] slot;
  logic [PW-1:0] psum;
  logic          wr, ctrl, clr_one, clr_all;
  stg_t          s1, s2;
  logic [AW-3:0] ri, idx;
  logic [DW-2:0] q;
  logic [DW-1:0] sq, tv, samp;
  logic          msb;
  logic          unused_bits;

  assign wr      = bus.cfg_we && !rst;
  assign ctrl    = wr && (bus.cfg_addr == CFG_CTRL);
  assign clr_one = ctrl && bus.cfg_wdata[CTRL_CLR];
  assign clr_all = ctrl && bus.cfg_wdata[CTRL_SYNC];

  assign psum = acc[slot] + phase[slot];
  assign unused_bits = ^{psum, s2.ph};

  // per-channel freq/phase/mode registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        freq[i]  <= '0;
        phase[i] <= '0;
        mode[i]  <= SINE;
      end
    end else if (wr) begin
      unique case (1'b1)
        bus.cfg_addr == CFG_FREQ:
          freq[bus.cfg_ch] <= bus.cfg_wdata;
        bus.cfg_addr == CFG_PHASE:
          phase[bus.cfg_ch] <= bus.cfg_wdata;
        bus.cfg_addr == CFG_MODE:
          mode[bus.cfg_ch] <= mode_e'(bus.cfg_wdata[1:0]);
        default: ;
      endcase
    end
  end

  // accumulators: a clear beats same-cycle accumulation
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst || clr_all ||
          (clr_one && bus.cfg_ch == CW'(i)))
        acc[i] <= '0;
      else if (bus.en && slot == CW'(i))
        acc[i] <= acc[i] + freq[i];
    end
  end

  // slot counter, realigned to 0 by sync clear
  always_ff @(posedge clk) begin
    if (rst || clr_all) slot <= '0;
    else if (bus.en)    slot <= slot + 1'b1;
  end

  // S0 -> S1 -> S2 pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else if (bus.en) begin
      s1 <= '{v: 1'b1, ch: slot,
              mode: mode[slot],
              ph: psum[PW-1 -: HW]};
      s2 <= s1;
    end
  end

  // odd quadrants read the table mirrored
  always_comb begin
    ri  = s1.ph[HW-3 -: AW-2];
    idx = s1.ph[HW-2] ? ~ri : ri;
  end

  dds_quarter_lut #(
    .DW (DW),
    .AW (AW)
  ) u_lut (
    .clk (clk),
    .en  (bus.en),
    .idx (idx),
    .q   (q)
  );

  // waveform select from phase MSBs and ROM value
  always_comb begin
    msb  = s2.ph[HW-1];
    sq   = {1'b0, q};
    tv   = s2.ph[HW-2 -: DW];
    samp = '0;
    if (msb) tv = ~tv;
    unique case (s2.mode)
      SINE:   samp = msb ? -sq : sq;
      SQUARE: samp = msb ? -AMP : AMP;
      SAW:    samp = {~msb, s2.ph[HW-2 -: DW-1]};
      TRI:    samp = {~tv[DW-1], tv[DW-2:0]};
    endcase
  end

  // output register, holds while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out       <= '0;
      bus.out_ch    <= '0;
      bus.out_valid <= 1'b0;
      bus.out_frame <= 1'b0;
    end else begin
      bus.out_valid <= bus.en && s2.v;
      if (bus.en && s2.v) begin
        bus.out       <= samp;
        bus.out_ch    <= s2.ch;
        bus.out_frame <= (s2.ch == '0);
      end
    end
  end

endmodule

// File: tb/tb_dds_mc.sv
// tb_dds_mc: directed + random stimulus for dds_mc
// reference computes samples from ideal waveform maths
module tb_dds_mc;
  import dds_pkg::*;

  localparam int PW  = 32;
  localparam int DW  = 10;
  localparam int AW  = 13;
  localparam int NCH = 4;
  localparam int A   = 511;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;

  dds_mc_if #(.PW(PW), .DW(DW), .NCH(NCH)) bus ();

  dds_mc #(
    .PW  (PW),
    .DW  (DW),
    .AW  (AW),
    .NCH (NCH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] m_acc   [NCH];
  logic [PW-1:0] m_freq  [NCH];
  logic [PW-1:0] m_phase [NCH];
  int            m_mode  [NCH];
  int            m_slot;
  int            pipe_s[$];
  int            pipe_c[$];
  int            ev, e_out, e_ch, e_frame;
  int            nas = 0;
  int            nfail = 0;

  function automatic int ref_sample(int md, logic [31:0] ps);
    real v;
    int  n, m, u;
    case (md)
      0: begin
        n = int'(ps >> 19);
        v = A * $sin(2.0 * PI * (n + 0.5) / 8192.0);
        m = $rtoi((v < 0.0 ? -v : v) + 0.5);
        return (v < 0.0) ? -m : m;
      end
      1: return ps[31] ? -A : A;
      2: return int'(ps >> 22) - 512;
      default: begin
        u = int'(ps >> 21);
        return ((u < 1024) ? u : 2047 - u) - 512;
      end
    endcase
  endfunction

  task automatic chk(string tag, int obs, int exp);
    nas++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    int s, a;
    logic [PW-1:0] d;
    ev = 0;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_acc[i] = '0; m_freq[i] = '0;
        m_phase[i] = '0; m_mode[i] = 0;
      end
      m_slot = 0;
      pipe_s.delete();
      pipe_c.delete();
      e_out = 0; e_ch = 0; e_frame = 0;
    end else begin
      if (bus.en) begin
        s = m_slot;
        pipe_s.push_back(
          ref_sample(m_mode[s], m_acc[s] + m_phase[s]));
        pipe_c.push_back(s);
        m_acc[s] = m_acc[s] + m_freq[s];
        m_slot = (m_slot + 1) % NCH;
        if (pipe_s.size() == 3) begin
          ev = 1;
          e_out = pipe_s.pop_front();
          e_ch = pipe_c.pop_front();
          e_frame = int'(e_ch == 0);
        end
      end
      if (bus.cfg_we) begin
        s = int'(bus.cfg_ch);
        a = int'(bus.cfg_addr);
        d = bus.cfg_wdata;
        case (a)
          0: m_freq[s] = d;
          1: m_phase[s] = d;
          2: m_mode[s] = int'(d[1:0]);
          default: begin
            if (d[0]) m_acc[s] = '0;
            if (d[1]) begin
              for (int i = 0; i < NCH; i++) m_acc[i] = '0;
              m_slot = 0;
            end
          end
        endcase
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", int'(bus.out_valid), ev);
    chk("out", int'(bus.out), e_out);
    chk("out_ch", int'(bus.out_ch), e_ch);
    chk("out_frame", int'(bus.out_frame), e_frame);
  endtask

  task automatic wr(int ch, logic [1:0] addr, logic [PW-1:0] d);
    bus.cfg_ch    = 2'(ch);
    bus.cfg_addr  = addr;
    bus.cfg_wdata = d;
    bus.cfg_we    = 1'b1;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  initial begin
    int pat[4];
    int c, exp;
    pat = '{0, 511, 0, -511};
    rst = 1'b1;
    bus.en = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_ch = '0;
    bus.cfg_addr = '0;
    bus.cfg_wdata = '0;
    tick();
    wr(0, CFG_FREQ, 32'h1234_5678);
    tick();
    rst = 1'b0;
    bus.en = 1'b1;

    for (int k = 0; k < 12; k++) begin
      tick();
      chk("first_valid", int'(bus.out_valid), int'(k >= 2));
      if (k >= 2)
        chk("start_ch", int'(bus.out_ch), (k - 2) % 4);
    end

    wr(0, CFG_FREQ, 32'h4000_0000);
    wr(1, CFG_MODE, 32'd1);
    wr(1, CFG_PHASE, 32'h8000_0000);
    wr(2, CFG_MODE, 32'd2);
    wr(2, CFG_FREQ, 32'h0040_0000);
    wr(0, CFG_CTRL, 32'd2);
    tick();
    tick();
    for (int k = 0; k < 16; k++) begin
      tick();
      c = k % 4;
      exp = (c == 0) ? pat[k / 4] :
            (c == 1) ? -511 :
            (c == 2) ? -512 + k / 4 : 0;
      chk("dir_ch", int'(bus.out_ch), c);
      chk("dir_out", int'(bus.out), exp);
      chk("dir_frame", int'(bus.out_frame), int'(c == 0));
    end

    wr(1, CFG_PHASE, 32'd0);
    wr(3, CFG_MODE, 32'd3);
    wr(3, CFG_FREQ, 32'h0100_0000);
    for (int k = 0; k < 4200; k++) tick();

    bus.en = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    bus.en = 1'b1;
    for (int k = 0; k < 12; k++) tick();

    for (int k = 0; k < 600; k++) begin
      bus.en = 1'(($urandom % 5) != 0);
      if ($urandom % 6 == 0) begin
        bus.cfg_ch   = 2'($urandom % NCH);
        bus.cfg_addr = 2'($urandom % 4);
        bus.cfg_wdata = (bus.cfg_addr == CFG_CTRL) ?
                        32'($urandom % 4) : $urandom;
        bus.cfg_we = 1'b1;
      end else begin
        bus.cfg_we = 1'b0;
      end
      tick();
    end
    bus.cfg_we = 1'b0;
    bus.en = 1'b1;
    for (int k = 0; k < 8; k++) tick();

    rst = 1'b1;
    bus.cfg_ch = 2'd3;
    bus.cfg_addr = CFG_FREQ;
    bus.cfg_wdata = 32'h2000_0000;
    bus.cfg_we = 1'b1;
    tick();
    tick();
    bus.cfg_we = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nas, nfail);
    $finish;
  end

endmodule
